// File: rtl/button_pulse_generator_pkg.sv
// button_pulse_generator_pkg: FSM state encoding and default timing constants for the button front end.
package button_pulse_generator_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        DB_REL   = 3'd4
    } state_e;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_DEBOUNCE_CYC  = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
    localparam int DEF_CNT_W         = 26;
endpackage

// File: rtl/button_pulse_generator_if.sv
// button_pulse_generator_if: raw board inputs in, clean count requests out.
interface button_pulse_generator_if;
    logic pushButton;
    logic slideSwitch;
    logic countPulse;
    logic upDown;
    logic buttonHeld;
    logic repeating;
    modport master (output pushButton, slideSwitch, input countPulse, upDown, buttonHeld, repeating);
    modport slave  (input pushButton, slideSwitch, output countPulse, upDown, buttonHeld, repeating);
endinterface

// File: rtl/button_pulse_generator_sync_ff.sv
// sync_ff: STAGES-deep flip-flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/button_pulse_generator.sv
// button_pulse_generator: debounces a push button into single-cycle count pulses with auto-repeat,
// sampling the direction switch on every pulse.
module button_pulse_generator import button_pulse_generator_pkg::*; #(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input logic CLK,
    input logic RESET,
    button_pulse_generator_if.slave bus
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic btn_s, sw_s;
    state_e state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic pulse_q, pulse_d, up_q, up_d, held_q, held_d, rep_q, rep_d;
    sync_ff #(.STAGES(SYNC_STAGES)) u_btn_sync (.clk(CLK), .rst(RESET), .d_i(bus.pushButton),  .q_o(btn_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sw_sync  (.clk(CLK), .rst(RESET), .d_i(bus.slideSwitch), .q_o(sw_s));
    // saturating so a long stay in IDLE never wraps into a false match
    assign timer_inc = (&timer_q) ? timer_q : timer_q + CNT_W'(1);
    always_comb begin
        state_d = state_q;
        timer_d = timer_inc;
        pulse_d = 1'b0;
        up_d    = up_q;
        held_d  = held_q;
        rep_d   = rep_q;
        case (state_q)
            IDLE: if (btn_s) begin
                state_d = DB_PRESS;
                timer_d = '0;
            end
            DB_PRESS: if (!btn_s) begin
                state_d = IDLE;
                timer_d = '0;
            end else if (timer_q == DB_LAST) begin
                state_d = HELD;
                timer_d = '0;
                pulse_d = 1'b1;
                up_d    = sw_s;
                held_d  = 1'b1;
            end
            HELD: if (!btn_s) begin
                state_d = DB_REL;
                timer_d = '0;
            end else if (timer_q == DLY_LAST) begin
                state_d = REPEAT;
                timer_d = '0;
                pulse_d = 1'b1;
                up_d    = sw_s;
                rep_d   = 1'b1;
            end
            REPEAT: if (!btn_s) begin
                state_d = DB_REL;
                timer_d = '0;
            end else if (timer_q == PER_LAST) begin
                timer_d = '0;
                pulse_d = 1'b1;
                up_d    = sw_s;
            end
            DB_REL: if (btn_s) begin
                state_d = HELD;
                timer_d = '0;
                rep_d   = 1'b0;
            end else if (timer_q == DB_LAST) begin
                state_d = IDLE;
                timer_d = '0;
                held_d  = 1'b0;
                rep_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state_q <= IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            up_q    <= 1'b0;
            held_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            up_q    <= up_d;
            held_q  <= held_d;
            rep_q   <= rep_d;
        end
    assign bus.countPulse = pulse_q;
    assign bus.upDown     = up_q;
    assign bus.buttonHeld = held_q;
    assign bus.repeating  = rep_q;
endmodule

// File: tb/tb_button_pulse_generator.sv
// tb_button_pulse_generator: directed tables, corner sequences and random stimulus against a run-length reference model.
module tb_button_pulse_generator;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    typedef struct {
        int   t;
        logic pulse;
        logic up;
        logic held;
        logic rep;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    button_pulse_generator_if bus();
    button_pulse_generator #(
        .SYNC_STAGES(2), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(26)
    ) dut (.CLK(clk), .RESET(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    int t;
    int pulses;
    int any_held;
    int any_rep;
    // model: input delay line plus run-length counters of the synchronized button
    logic s1, s2, w1, w2;
    int ones, zeros, age;
    logic m_held, m_rep, m_up, m_pulse;
    vec_t tbl[$];
    logic r_pb, r_sw;
    int run;
    int k;
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %0d, want %0d", name, t, act, exp);
        end
    endtask
    task automatic model_reset();
        s1 = 0; s2 = 0; w1 = 0; w2 = 0;
        ones = 0; zeros = 0; age = 0;
        m_held = 0; m_rep = 0; m_up = 0; m_pulse = 0;
    endtask
    task automatic model_edge(input logic pb, input logic sw);
        logic b, ws;
        b = s2; ws = w2;
        s2 = s1; s1 = pb; w2 = w1; w1 = sw;
        m_pulse = 0;
        if (!m_held) begin
            ones = b ? ones + 1 : 0;
            if (ones == DEB + 1) begin
                m_pulse = 1; m_held = 1; m_up = ws; m_rep = 0;
                age = 0; zeros = 0; ones = 0;
            end
        end else if (!b) begin
            zeros++;
            if (zeros == DEB + 1) begin
                m_held = 0; m_rep = 0; zeros = 0;
            end
        end else if (zeros > 0) begin
            zeros = 0; age = 0; m_rep = 0;
        end else begin
            age++;
            if (age == (m_rep ? PER : DLY)) begin
                m_pulse = 1; m_rep = 1; m_up = ws; age = 0;
            end
        end
    endtask
    task automatic tick(input logic pb, input logic sw);
        bus.pushButton = pb;
        bus.slideSwitch = sw;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(pb, sw);
        @(negedge clk);
        check("countPulse", int'(bus.countPulse), int'(m_pulse));
        check("upDown", int'(bus.upDown), int'(m_up));
        check("buttonHeld", int'(bus.buttonHeld), int'(m_held));
        check("repeating", int'(bus.repeating), int'(m_rep));
        if (bus.countPulse) pulses++;
        if (bus.buttonHeld) any_held++;
        if (bus.repeating) any_rep++;
    endtask
    initial begin
        rst = 1'b1;
        bus.pushButton = 1'b0;
        bus.slideSwitch = 1'b0;
        model_reset();
        t = -1;
        tick(0, 0);
        tick(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, 1);
        // hold with direction change mid-hold: sparse expected-value table
        tbl.push_back('{5,  0, 0, 0, 0});
        tbl.push_back('{6,  1, 1, 1, 0});
        tbl.push_back('{7,  0, 1, 1, 0});
        tbl.push_back('{15, 0, 1, 1, 0});
        tbl.push_back('{16, 1, 1, 1, 1});
        tbl.push_back('{17, 0, 1, 1, 1});
        tbl.push_back('{19, 1, 0, 1, 1});
        tbl.push_back('{22, 1, 0, 1, 1});
        tbl.push_back('{25, 1, 0, 1, 1});
        tbl.push_back('{28, 1, 0, 1, 1});
        tbl.push_back('{31, 0, 0, 1, 1});
        tbl.push_back('{34, 0, 0, 1, 1});
        tbl.push_back('{35, 0, 0, 0, 0});
        tbl.push_back('{40, 0, 0, 0, 0});
        pulses = 0;
        k = 0;
        for (int i = 0; i < 42; i++) begin
            t = i;
            tick(i <= 28, i < 17);
            if (k < tbl.size() && tbl[k].t == i) begin
                check("tbl_pulse", int'(bus.countPulse), int'(tbl[k].pulse));
                check("tbl_up", int'(bus.upDown), int'(tbl[k].up));
                check("tbl_held", int'(bus.buttonHeld), int'(tbl[k].held));
                check("tbl_rep", int'(bus.repeating), int'(tbl[k].rep));
                k++;
            end
        end
        check("hold_pulse_count", pulses, 6);
        // clean short press
        pulses = 0; any_rep = 0;
        for (int i = 0; i < 16; i++) begin
            t = i;
            tick(i < 6, 0);
            if (i == 5) check("press_no_early", int'(bus.countPulse), 0);
            if (i == 6) begin
                check("press_pulse_t6", int'(bus.countPulse), 1);
                check("press_held_t6", int'(bus.buttonHeld), 1);
            end
        end
        check("press_pulse_count", pulses, 1);
        check("press_no_repeat", any_rep, 0);
        check("press_released", int'(bus.buttonHeld), 0);
        // bounce only
        pulses = 0; any_held = 0;
        for (int i = 0; i < 14; i++) begin
            t = i;
            tick(i < 4 && (i % 2 == 0), 0);
        end
        check("bounce_pulses", pulses, 0);
        check("bounce_held", any_held, 0);
        // two-cycle release glitch while held
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            t = i;
            tick(i <= 18 && i != 8 && i != 9, 0);
            if (i >= 7 && i <= 20) check("glitch_held", int'(bus.buttonHeld), 1);
        end
        check("glitch_pulses", pulses, 1);
        // reset in the middle of a hold
        pulses = 0;
        for (int i = 0; i <= 8; i++) begin
            t = i;
            tick(1, 1);
        end
        check("pre_reset_held", int'(bus.buttonHeld), 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_pulse", int'(bus.countPulse), 0);
        check("rst_up", int'(bus.upDown), 0);
        check("rst_held", int'(bus.buttonHeld), 0);
        check("rst_rep", int'(bus.repeating), 0);
        tick(1, 1);
        tick(1, 1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = i;
            tick(1, 1);
            if (i == 5) check("post_rst_no_early", int'(bus.countPulse), 0);
            if (i == 6) begin
                check("post_rst_pulse_t6", int'(bus.countPulse), 1);
                check("post_rst_up", int'(bus.upDown), 1);
            end
        end
        for (int i = 0; i < 10; i++) tick(0, 0);
        // random runs of button levels, switch flips and occasional resets
        r_pb = 0; r_sw = 0; run = 0;
        for (int i = 0; i < 1500; i++) begin
            t = i;
            if (run == 0) begin
                r_pb = ~r_pb;
                run = $urandom_range(1, 25);
            end
            run--;
            if ($urandom_range(0, 9) == 0) r_sw = ~r_sw;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                model_reset();
            end else rst = 1'b0;
            tick(r_pb, r_sw);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
